// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch stage: fetch entry layout, FSM states
// and the NOP word used to fill misaligned-fetch fault entries.
package ifetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FAULT = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/ifetch_if.sv
// Bundle between ifetch and its surroundings: ROM read port, redirect input,
// decode-side output handshake and a debug view of the FSM and FIFO occupancy.
interface ifetch_if;
    import ifetch_pkg::*;

    logic [63:0] HADDR;
    logic [63:0] HWDATA;
    logic        HWRITE;
    logic [63:0] HRDATA;

    logic        redirect_valid;
    logic [63:0] redirect_pc;

    // An entry transfers on a rising edge where out_valid & out_ready are both
    // high; out_valid never looks at out_ready and head fields hold while stalled.
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;

    state_t      dbg_state;
    logic [7:0]  dbg_count;

    modport master (
        output HADDR, HWDATA, HWRITE,
        input  HRDATA,
        input  redirect_valid, redirect_pc,
        output out_valid, out_pc, out_inst, out_fault,
        input  out_ready,
        output dbg_state, dbg_count
    );

    modport slave (
        input  HADDR, HWDATA, HWRITE,
        output HRDATA,
        output redirect_valid, redirect_pc,
        input  out_valid, out_pc, out_inst, out_fault,
        output out_ready,
        input  dbg_state, dbg_count
    );

endinterface

// File: rtl/ifetch_fetch_fifo.sv
// Small synchronous FIFO for prefetched instructions. Flush beats push/pop;
// a push into a full FIFO succeeds only when a pop happens in the same cycle.
module fetch_fifo #(
    parameter int   WIDTH = 8,
    parameter int   DEPTH = 2,
    localparam int  AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, reads the ROM combinationally and
// queues {pc, inst, fault} entries for decode; redirects flush the queue.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic            HCLK,
    input  logic            HRESET,
    ifetch_if.master        bus
);

    state_t                    state, state_nx;
    logic [63:0]               fetch_pc, fetch_pc_nx;
    logic [63:0]               fault_pc, fault_pc_nx;
    logic                      push, pop, flush;
    logic                      full, empty, space;
    logic [$clog2(FIFO_DEPTH):0] count;
    fetch_entry_t              din, head;
    logic                      unused_hrdata_hi;

    assign pop   = !empty && bus.out_ready;
    assign space = !full || pop;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            fault_pc <= '0;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            fault_pc <= fault_pc_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        fault_pc_nx = fault_pc;
        push        = 1'b0;
        flush       = 1'b0;
        din         = '{pc: fetch_pc, inst: bus.HRDATA[31:0], fault: 1'b0};
        if (bus.redirect_valid) begin
            flush = 1'b1;
            if (bus.redirect_pc[1:0] == 2'b00) begin
                fetch_pc_nx = bus.redirect_pc;
                state_nx    = RUN;
            end else begin
                // Misaligned target: keep the old PC, report it once as a fault entry.
                fault_pc_nx = bus.redirect_pc;
                state_nx    = FAULT;
            end
        end else begin
            case (state)
                RUN: begin
                    if (space) begin
                        push        = 1'b1;
                        fetch_pc_nx = fetch_pc + 64'd4;
                    end
                end
                FAULT: begin
                    din = '{pc: fault_pc, inst: NOP_INST, fault: 1'b1};
                    if (space) begin
                        push     = 1'b1;
                        state_nx = HALT;
                    end
                end
                HALT:    state_nx = HALT;
                default: state_nx = RUN;
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (din),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign bus.HADDR     = fetch_pc;
    assign bus.HWDATA    = 64'h0;
    assign bus.HWRITE    = 1'b0;
    assign bus.out_valid = !empty;
    assign bus.out_pc    = head.pc;
    assign bus.out_inst  = head.inst;
    assign bus.out_fault = head.fault;
    assign bus.dbg_state = state;
    assign bus.dbg_count = 8'(count);

    assign unused_hrdata_hi = ^bus.HRDATA[63:32];

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a behavioural ROM, two DUTs (RESET_PC 0 and
// 0x...FFFC) and a queue scoreboard that checks every accepted output entry.
module tb_ifetch;
    import ifetch_pkg::*;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    logic [96:0] exp_q[$];
    logic [96:0] exp_qb[$];

    ifetch_if a_if ();
    ifetch_if b_if ();

    ifetch #(.RESET_PC(64'h0), .FIFO_DEPTH(2)) dut_a (
        .HCLK   (clk),
        .HRESET (rst_a),
        .bus    (a_if)
    );

    ifetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .FIFO_DEPTH(2)) dut_b (
        .HCLK   (clk),
        .HRESET (rst_b),
        .bus    (b_if)
    );

    // Clock and ROM
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rom_word(logic [63:0] a);
        logic [7:0] b0, b1, b2, b3;
        if (a == 64'h0) return 32'h00400093;
        if (a == 64'h4) return 32'h00803103;
        b0 = a[7:0];
        b1 = 8'(a + 64'd1);
        b2 = 8'(a + 64'd2);
        b3 = 8'(a + 64'd3);
        return {b3, b2, b1, b0};
    endfunction

    assign a_if.HRDATA = {~rom_word(a_if.HADDR), rom_word(a_if.HADDR)};
    assign b_if.HRDATA = {~rom_word(b_if.HADDR), rom_word(b_if.HADDR)};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, score any accepted entry, then
    // advance to just after the next rising edge.
    task automatic cycle();
        logic [96:0] e;
        @(negedge clk);
        chk("hwrite", {127'h0, a_if.HWRITE}, 128'h0);
        chk("hwdata", {64'h0, a_if.HWDATA}, 128'h0);
        if (a_if.out_valid && a_if.out_ready && !rst_a && !a_if.redirect_valid) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            chk("a_entry", {a_if.out_pc, a_if.out_inst, a_if.out_fault}, e);
        end
        if (b_if.out_valid && b_if.out_ready && !rst_b && !b_if.redirect_valid) begin
            e = (exp_qb.size() != 0) ? exp_qb.pop_front() : 'x;
            chk("b_entry", {b_if.out_pc, b_if.out_inst, b_if.out_fault}, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        a_if.out_ready = 1'b0;
        a_if.redirect_valid = 1'b0;
        a_if.redirect_pc = 64'h0;
        b_if.out_ready = 1'b0;
        b_if.redirect_valid = 1'b0;
        b_if.redirect_pc = 64'h0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_valid", a_if.out_valid, 0);
        chk("rst_pc", a_if.out_pc, 0);
        chk("rst_inst", a_if.out_inst, 0);
        chk("rst_fault", a_if.out_fault, 0);
        chk("rst_haddr", a_if.HADDR, 0);
        chk("rst_state", a_if.dbg_state, RUN);
        chk("rst_count", a_if.dbg_count, 0);

        // 1: streaming from reset with out_ready=1
        rst_a = 1'b0;
        a_if.out_ready = 1'b1;
        exp_q.push_back({64'h0, 32'h00400093, 1'b0});
        exp_q.push_back({64'h4, 32'h00803103, 1'b0});
        exp_q.push_back({64'h8, 32'h0B0A0908, 1'b0});
        chk("t1_first_empty", a_if.out_valid, 0);
        repeat (4) cycle();
        a_if.out_ready = 1'b0;
        chk("t1_drained", exp_q.size(), 0);

        // 2: stall after reset, then release
        rst_a = 1'b1;
        cycle();
        rst_a = 1'b0;
        repeat (5) cycle();
        chk("t2_count", a_if.dbg_count, 2);
        chk("t2_haddr", a_if.HADDR, 64'h8);
        chk("t2_out_pc", a_if.out_pc, 64'h0);
        chk("t2_valid", a_if.out_valid, 1);
        a_if.out_ready = 1'b1;
        exp_q.push_back({64'h0, 32'h00400093, 1'b0});
        exp_q.push_back({64'h4, 32'h00803103, 1'b0});
        exp_q.push_back({64'h8, 32'h0B0A0908, 1'b0});
        exp_q.push_back({64'hC, 32'h0F0E0D0C, 1'b0});
        repeat (4) cycle();
        chk("t2_drained", exp_q.size(), 0);

        // 3: aligned redirect while full and ready
        chk("t3_full", a_if.dbg_count, 2);
        a_if.redirect_valid = 1'b1;
        a_if.redirect_pc = 64'h40;
        cycle();
        a_if.redirect_valid = 1'b0;
        chk("t3_flush_valid", a_if.out_valid, 0);
        chk("t3_haddr", a_if.HADDR, 64'h40);
        exp_q.push_back({64'h40, 32'h43424140, 1'b0});
        repeat (2) cycle();
        a_if.out_ready = 1'b0;
        chk("t3_drained", exp_q.size(), 0);
        repeat (2) cycle();

        // 4: misaligned redirect -> fault entry, halt, recover
        a_if.out_ready = 1'b1;
        a_if.redirect_valid = 1'b1;
        a_if.redirect_pc = 64'h42;
        exp_q.push_back({64'h42, NOP_INST, 1'b1});
        cycle();
        a_if.redirect_valid = 1'b0;
        chk("t4_valid0", a_if.out_valid, 0);
        chk("t4_state_fault", a_if.dbg_state, FAULT);
        repeat (2) cycle();
        chk("t4_drained", exp_q.size(), 0);
        for (int i = 0; i < 10; i++) begin
            chk("t4_halt_valid", a_if.out_valid, 0);
            chk("t4_halt_haddr", a_if.HADDR, 64'h4C);
            chk("t4_halt_state", a_if.dbg_state, HALT);
            cycle();
        end
        a_if.redirect_valid = 1'b1;
        a_if.redirect_pc = 64'h10;
        exp_q.push_back({64'h10, 32'h13121110, 1'b0});
        cycle();
        a_if.redirect_valid = 1'b0;
        chk("t4_recover_valid0", a_if.out_valid, 0);
        repeat (2) cycle();
        a_if.out_ready = 1'b0;
        chk("t4_recover_drained", exp_q.size(), 0);

        // 6: reset and redirect together mid-stream
        repeat (2) cycle();
        chk("t6_full", a_if.dbg_count, 2);
        rst_a = 1'b1;
        a_if.redirect_valid = 1'b1;
        a_if.redirect_pc = 64'h80;
        a_if.out_ready = 1'b1;
        cycle();
        rst_a = 1'b0;
        a_if.redirect_valid = 1'b0;
        chk("t6_valid0", a_if.out_valid, 0);
        chk("t6_haddr", a_if.HADDR, 64'h0);
        chk("t6_state", a_if.dbg_state, RUN);
        exp_q.push_back({64'h0, 32'h00400093, 1'b0});
        repeat (2) cycle();
        a_if.out_ready = 1'b0;
        chk("t6_drained", exp_q.size(), 0);

        // 5: PC wrap on the second DUT
        rst_b = 1'b0;
        chk("t5_haddr_reset", b_if.HADDR, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_valid0", b_if.out_valid, 0);
        cycle();
        chk("t5_haddr_wrap", b_if.HADDR, 64'h0);
        chk("t5_count1", b_if.dbg_count, 1);
        cycle();
        chk("t5_count2", b_if.dbg_count, 2);
        exp_qb.push_back({64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFEFDFC, 1'b0});
        exp_qb.push_back({64'h0, 32'h00400093, 1'b0});
        b_if.out_ready = 1'b1;
        repeat (2) cycle();
        b_if.out_ready = 1'b0;
        chk("t5_drained", exp_qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
